// File: rtl/alu_issue_ctrl.sv
// Single-issue controller: owns an NREG x WIDTH register file, executes load-immediate
// in one edge and ALU operations through an external ALU over a two-state IDLE/EXEC FSM.
module alu_issue_ctrl #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_load,
    input  logic [1:0]       in_op,
    input  logic [2:0]       in_rd,
    input  logic [2:0]       in_rs1,
    input  logic [2:0]       in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_i0,
    output logic [WIDTH-1:0] alu_i1,
    input  logic [WIDTH-1:0] alu_o,
    input  logic             alu_cout,
    output logic             done,
    output logic             carry_flag,
    output logic [15:0]      op_count,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [2:0]       rd_q;
    logic [WIDTH-1:0] rf [NREG];

    assign in_ready = (state == IDLE) && !reset;
    assign dbg_data = rf[dbg_addr];

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (!in_load) begin
                        state_next = EXEC;
                    end
                end
            end
            EXEC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reset wins over accept and discards any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            alu_op     <= '0;
            alu_i0     <= '0;
            alu_i1     <= '0;
            rd_q       <= '0;
            carry_flag <= 1'b0;
            done       <= 1'b0;
            op_count   <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (accept && in_load) begin
                rf[in_rd] <= in_imm;
                done      <= 1'b1;
                op_count  <= op_count + 16'd1;
            end
            // Operands sample rf before any same-edge write, so rs == rd sees the old value.
            if (accept && !in_load) begin
                alu_op <= in_op;
                alu_i0 <= rf[in_rs1];
                alu_i1 <= rf[in_rs2];
                rd_q   <= in_rd;
            end
            if (state == EXEC) begin
                rf[rd_q]   <= alu_o;
                carry_flag <= alu_cout;
                done       <= 1'b1;
                op_count   <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, corner-case sequences and
// randomized instructions compared against an architectural register/flag/counter model.
module tb_alu_issue_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             in_load;
    logic [1:0]       in_op;
    logic [2:0]       in_rd, in_rs1, in_rs2;
    logic [WIDTH-1:0] in_imm;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_i0, alu_i1, alu_o;
    logic             alu_cout;
    logic             done;
    logic             carry_flag;
    logic [15:0]      op_count;
    logic [2:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    alu_issue_ctrl #(.WIDTH(WIDTH), .NREG(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_load(in_load), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .alu_op(alu_op), .alu_i0(alu_i0), .alu_i1(alu_i1),
        .alu_o(alu_o), .alu_cout(alu_cout), .done(done), .carry_flag(carry_flag),
        .op_count(op_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 00 add, 01 subtract (bit 16 = borrow), 10 and, 11 xor.
    function automatic logic [16:0] alu_fn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    always_comb {alu_cout, alu_o} = alu_fn(alu_op, alu_i0, alu_i1);

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    always @(negedge clk) if (done === 1'b1) done_pulses++;

    // Architectural reference state
    logic [15:0] ref_rf [8];
    logic [15:0] ref_count;
    logic        ref_carry;
    logic [1:0]  ref_op;
    logic [15:0] ref_i0, ref_i1;

    typedef struct {
        bit        load;
        bit [1:0]  op;
        bit [2:0]  rd, rs1, rs2;
        bit [15:0] imm;
        bit [15:0] exp_val;
        bit        exp_carry;
        bit [15:0] exp_count;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic read_reg(input logic [2:0] r, output logic [15:0] v);
        dbg_addr = r;
        #1;
        v = dbg_data;
    endtask

    task automatic ref_clear();
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
        ref_count = '0;
        ref_carry = 1'b0;
        ref_op    = '0;
        ref_i0    = '0;
        ref_i1    = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        in_valid = 1'b0;
        idle(2);
        reset = 1'b0;
        ref_clear();
    endtask

    task automatic do_load(input logic [2:0] rd, input logic [15:0] imm);
        logic [15:0] v;
        in_valid = 1'b1; in_load = 1'b1; in_rd = rd; in_imm = imm;
        in_op = 2'($urandom); in_rs1 = 3'($urandom); in_rs2 = 3'($urandom);
        check("load_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        ref_rf[rd] = imm;
        ref_count++;
        check("load_done", done, 1);
        check("load_count", op_count, ref_count);
        check("load_carry", carry_flag, ref_carry);
        check("load_alu_hold", {alu_op, alu_i0, alu_i1}, {ref_op, ref_i0, ref_i1});
        read_reg(rd, v);
        check("load_wb", v, imm);
    endtask

    task automatic do_alu(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input bit noise);
        logic [16:0] exp;
        logic [15:0] v;
        exp = alu_fn(op, ref_rf[rs1], ref_rf[rs2]);
        in_valid = 1'b1; in_load = 1'b0; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = 16'($urandom);
        check("alu_ready", in_ready, 1);
        @(posedge clk); #1;
        // An offer made during EXEC must be dropped, not queued.
        if (noise) begin
            in_valid = 1'b1; in_load = 1'b1; in_rd = 3'($urandom); in_imm = 16'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        ref_op = op; ref_i0 = ref_rf[rs1]; ref_i1 = ref_rf[rs2];
        check("exec_ready", in_ready, 0);
        check("exec_done", done, 0);
        check("exec_alu", {alu_op, alu_i0, alu_i1}, {ref_op, ref_i0, ref_i1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("wb_alu_hold", {alu_op, alu_i0, alu_i1}, {ref_op, ref_i0, ref_i1});
        ref_rf[rd] = exp[15:0];
        ref_carry  = exp[16];
        ref_count++;
        check("alu_done", done, 1);
        check("alu_carry", carry_flag, ref_carry);
        check("alu_count", op_count, ref_count);
        read_reg(rd, v);
        check("alu_wb", v, ref_rf[rd]);
    endtask

    initial begin
        logic [15:0] v;
        int          snap;
        int          accepts;

        reset = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_op = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; dbg_addr = '0;
        reset_dut();

        // Reset state
        for (int r = 0; r < 8; r++) begin
            read_reg(3'(r), v);
            check($sformatf("reset_rf%0d", r), v, 16'h0000);
        end
        check("reset_ready", in_ready, 1);
        check("reset_count", op_count, 0);
        check("reset_carry", carry_flag, 0);
        check("reset_done", done, 0);
        check("reset_alu", {alu_op, alu_i0, alu_i1}, 34'd0);

        // Directed vectors with hand-computed results
        vecs[0] = '{1'b1, 2'd0, 3'd1, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 16'd1};
        vecs[1] = '{1'b1, 2'd0, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 1'b0, 16'd2};
        vecs[2] = '{1'b0, 2'd0, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h0000, 1'b1, 16'd3};
        vecs[3] = '{1'b1, 2'd0, 3'd1, 3'd0, 3'd0, 16'hAA55, 16'hAA55, 1'b1, 16'd4};
        vecs[4] = '{1'b1, 2'd0, 3'd2, 3'd0, 3'd0, 16'h55AA, 16'h55AA, 1'b1, 16'd5};
        vecs[5] = '{1'b0, 2'd0, 3'd1, 3'd1, 3'd2, 16'h0000, 16'hFFFF, 1'b0, 16'd6};
        vecs[6] = '{1'b0, 2'd0, 3'd5, 3'd5, 3'd5, 16'h0000, 16'h0000, 1'b0, 16'd7};
        vecs[7] = '{1'b1, 2'd0, 3'd6, 3'd0, 3'd0, 16'h8000, 16'h8000, 1'b0, 16'd8};
        vecs[8] = '{1'b0, 2'd0, 3'd6, 3'd6, 3'd6, 16'h0000, 16'h0000, 1'b1, 16'd9};
        vecs[9] = '{1'b0, 2'd0, 3'd7, 3'd6, 3'd1, 16'h0000, 16'hFFFF, 1'b0, 16'd10};

        snap = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                idle(1);
                snap = done_pulses;
            end
            if (vecs[i].load) do_load(vecs[i].rd, vecs[i].imm);
            else              do_alu(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, 1'b0);
            read_reg(vecs[i].rd, v);
            check($sformatf("vec%0d_val", i), v, vecs[i].exp_val);
            check($sformatf("vec%0d_carry", i), carry_flag, vecs[i].exp_carry);
            check($sformatf("vec%0d_count", i), op_count, vecs[i].exp_count);
            if (i == 5) begin
                idle(1);
                check("three_done_pulses", done_pulses - snap, 3);
                check("idle_done_low", done, 0);
            end
        end

        // in_valid held with an ALU instruction for four cycles
        in_valid = 1'b1; in_load = 1'b0; in_op = 2'd0; in_rd = 3'd4; in_rs1 = 3'd1; in_rs2 = 3'd2;
        accepts = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold_ready%0d", i), in_ready, (i % 2 == 0) ? 1 : 0);
            if (in_ready) accepts++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ref_rf[4] = 16'(ref_rf[1] + ref_rf[2]);
        ref_carry = alu_fn(2'd0, ref_rf[1], ref_rf[2]) >> 16;
        ref_count = ref_count + 16'd2;
        check("hold_accepts", accepts, 2);
        check("hold_count", op_count, ref_count);
        read_reg(3'd4, v);
        check("hold_r4", v, ref_rf[4]);

        // Randomized instruction stream, with noise offered during EXEC
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) == 0)
                do_load(3'($urandom), 16'($urandom));
            else
                do_alu(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
                check("rand_idle_done", done, 0);
            end
        end
        for (int r = 0; r < 8; r++) begin
            read_reg(3'(r), v);
            check($sformatf("rand_rf%0d", r), v, ref_rf[r]);
        end

        // Reset priority over an accept in the same cycle
        reset = 1'b1; in_valid = 1'b1; in_load = 1'b1; in_rd = 3'd3; in_imm = 16'h5555;
        #1;
        check("rst_ready_low", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        ref_clear();
        check("rst_accept_done", done, 0);
        read_reg(3'd3, v);
        check("rst_accept_r3", v, 16'h0000);

        // Reset during EXEC aborts the operation
        do_load(3'd1, 16'h0003);
        do_load(3'd2, 16'h0004);
        in_valid = 1'b1; in_load = 1'b0; in_op = 2'd0; in_rd = 3'd4; in_rs1 = 3'd1; in_rs2 = 3'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ref_clear();
        check("abort_done", done, 0);
        check("abort_count", op_count, 0);
        read_reg(3'd4, v);
        check("abort_r4", v, 16'h0000);
        idle(1);
        check("abort_done_later", done, 0);
        check("abort_count_later", op_count, 0);
        check("abort_ready", in_ready, 1);

        // op_count wrap after 65535 back-to-back loads
        reset_dut();
        snap = done_pulses;
        in_valid = 1'b1; in_load = 1'b1; in_rd = 3'd0;
        for (int i = 0; i < 65535; i++) begin
            in_imm = 16'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ref_rf[0] = 16'd65534;
        ref_count = 16'hFFFF;
        check("wrap_pre_count", op_count, 16'hFFFF);
        idle(1);
        check("wrap_pulses", done_pulses - snap, 65535);
        read_reg(3'd0, v);
        check("wrap_r0", v, 16'd65534);
        do_load(3'd2, 16'h1234);
        check("wrap_count_zero", op_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, datapath width of registers, immediates and ALU operands.
REQ-002 Parameter: NREG, 8, number of architectural registers; register address fields are 3 bits.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; ports are named as follows.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  instruction offered this cycle.
REQ-007 in_ready  output  1  block can accept an instruction this cycle.
REQ-008 in_load  input  1  1 = load-immediate, 0 = ALU operation.
REQ-009 in_op  input  2  ALU operation code, forwarded unmodified to the ALU.
REQ-010 in_rd, in_rs1, in_rs2  input  3 each  destination and source register addresses.
REQ-011 in_imm  input  WIDTH  immediate data for load.
REQ-012 alu_op  output  2  operation code to the ALU's op input.
REQ-013 alu_i0, alu_i1  output  WIDTH each  operands to the ALU's i0/i1 inputs.
REQ-014 alu_o  input  WIDTH  ALU result.
REQ-015 alu_cout  input  1  ALU carry-out.
REQ-016 done  output  1  one-cycle pulse: an instruction has retired.
REQ-017 carry_flag  output  1  alu_cout captured by the last retired ALU operation.
REQ-018 op_count  output  16  count of retired instructions.
REQ-019 dbg_addr  input  3  debug register-file read address.
REQ-020 dbg_data  output  WIDTH  combinational read of rf[dbg_addr].

Function
REQ-021 The block SHALL contain an NREG x WIDTH register file rf, written only by this block.
REQ-022 FSM states SHALL be IDLE and EXEC; in_ready SHALL be 1 exactly when state is IDLE and reset is low.
REQ-023 Accept SHALL occur on a rising edge where in_valid && in_ready; in_valid while in_ready=0 SHALL be ignored (no buffering).
REQ-024 Load accept: rf[in_rd] <= in_imm at the accepting edge, state stays IDLE, done = 1 in the following cycle; carry_flag unchanged; alu_* outputs unchanged.
REQ-025 ALU accept: alu_op <= in_op, alu_i0 <= rf[in_rs1], alu_i1 <= rf[in_rs2], rd latched, state -> EXEC.
REQ-026 In EXEC (exactly one cycle) alu_* SHALL be held stable; at the closing edge rf[rd] <= alu_o, carry_flag <= alu_cout, state -> IDLE, done = 1 in the following cycle.
REQ-027 ALU-op latency: accept edge N, writeback edge N+1, done high during cycle N+1..N+2, next accept possible at edge N+2.
REQ-028 Operands SHALL be read from rf at the accept edge; rs1 = rs2 = rd is legal, and the sources read the pre-write value.
REQ-029 A register written by instruction k SHALL be visible to any instruction accepted after k's writeback edge, so no hazard logic is needed.
REQ-030 alu_op/alu_i0/alu_i1 SHALL be registered and hold their last values in IDLE.
REQ-031 op_count SHALL increment by 1 on each retirement (same edge done is set) and wrap 0xFFFF -> 0x0000.
REQ-032 dbg_data SHALL reflect writes from the edge after the write.
REQ-033 done SHALL be low in every cycle without a retirement; back-to-back loads SHALL produce consecutive done pulses.

Reset
REQ-034 Reset SHALL set every rf entry, alu_op, alu_i0, alu_i1, carry_flag, done and op_count to 0, and state to IDLE.
REQ-035 Reset asserted during EXEC SHALL abort the operation: no rf write, no done, no op_count increment.
REQ-036 Reset SHALL take priority over an accept in the same cycle.

Verification (bench uses a behavioural ALU model: op 00 = add with carry-out)
REQ-037 Reset, then read all 8 registers via dbg_addr -> dbg_data = 0x0000 each; in_ready = 1, op_count = 0.
REQ-038 Load r1=0xFFFF, r2=0x0001, then ADD r3=r1+r2 -> alu_i0 = 0xFFFF, alu_i1 = 0x0001 during EXEC; rf[3] = 0x0000; carry_flag = 1; op_count = 3.
REQ-039 Load r1=0xAA55, r2=0x55AA, ADD r1=r1+r2 -> rf[1] = 0xFFFF, carry_flag = 0; done pulses exactly 3 times.
REQ-040 Hold in_valid high with an ALU instruction for 4 cycles -> in_ready pattern 1,0,1,0; exactly 2 instructions accepted.
REQ-041 Assert reset in the EXEC cycle of ADD r4=r1+r2 -> rf[4] stays 0x0000, done stays 0, op_count = 0.
REQ-042 Preload op_count to 0xFFFF via 65535 loads, then retire one more -> op_count = 0x0000.
